// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the loopback UART.
//   - tx_state_t : transmitter FSM states (IDLE/START/DATA/STOP)
//   - rx_state_t : loopback receiver FSM states
//   - DEF_CLK_FREQ / DEF_BAUD : default clock and line rate
//   - FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
package uart_pkg;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;
  localparam int FRAME_BITS   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver fed by the looped-back transmit line.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   rx_in     in   serial line (idle high)
//   rx_data   out  last received byte (bits land as they are sampled)
//   rx_valid  out  one-cycle pulse when a frame ends with a good stop bit
//   frame_err out  sticky flag, set when a stop bit samples low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       rx_data_next;
  logic             rx_valid_next, frame_err_next;
  logic             rx_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
      rx_prev   <= rx_in;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt + 1'b1;
    bit_idx_next   = bit_idx;
    rx_data_next   = rx_data;
    rx_valid_next  = 1'b0;
    frame_err_next = frame_err;
    case (state)
      RX_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_in) state_next = RX_START;
      end
      RX_START: begin
        // Counting starts on the first low cycle, so CNT_HALF lands at mid-bit.
        // A line that is high again by then was a glitch, not a start bit.
        if (cnt == CNT_HALF) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        // From mid-start onward, every full bit period is another mid-bit point.
        if (cnt == CNT_LAST) begin
          cnt_next              = '0;
          rx_data_next[bit_idx] = rx_in;
          if (bit_idx == 3'd7) state_next = RX_STOP;
          else                 bit_idx_next = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_in) rx_valid_next  = 1'b1;
          else       frame_err_next = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loopback_tx.sv
// uart_loopback_tx: 8N1 UART transmitter whose line is exported and looped
// back into an internal receiver for hierarchical checking.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-low reset
//   start    in   transmit request; a rising edge starts a frame from IDLE
//   data_in  in   byte to send, captured when the frame starts
//   rx_out   out  registered serial line, idle high
// Internal observation points: rx_data, rx_valid, frame_err.
module uart_loopback_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       rx_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             start_d;
  logic             start_rise;
  logic             bit_done;
  logic             line_val;

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             rx_status_unused;

  assign start_rise = start & ~start_d;
  assign bit_done   = (baud_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      start_d  <= 1'b0;
      rx_out   <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      start_d  <= start;
      // The pin is registered from the current state, so the line trails the
      // FSM by one cycle: a start edge taken at edge k drives the line low
      // from edge k+1, and every bit still spans exactly CLKS_PER_BIT cycles.
      rx_out   <= line_val;
    end
  end

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    line_val      = 1'b1;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (start_rise) begin
          state_next = START;
          shift_next = data_in;
        end
      end
      START: begin
        line_val = 1'b0;
        if (bit_done) begin
          state_next    = DATA;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
        end
      end
      DATA: begin
        line_val = shift[bit_idx];
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 1'b1;
        end
      end
      STOP: begin
        line_val = 1'b1;
        if (bit_done) begin
          state_next    = IDLE;
          baud_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_rx_core #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .rx_in    (rx_out),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  // Receiver results are observed hierarchically only; nothing here consumes them.
  assign rx_status_unused = ^{rx_data, rx_valid, frame_err};

endmodule

// File: tb/tb_uart_loopback_tx.sv
// tb_uart_loopback_tx: randomized scenario bench for uart_loopback_tx.
// A short bit period keeps every frame well inside the cycle budget.
module tb_uart_loopback_tx;
  import uart_pkg::*;

  localparam int N     = 16;
  localparam int FRAME = FRAME_BITS * N;
  localparam int MAXC  = 24 * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       rx_out;

  int checks   = 0;
  int failures = 0;

  logic       cap_line  [MAXC];
  tx_state_t  cap_state [MAXC];
  int         valid_cnt;
  logic [7:0] valid_data;

  uart_loopback_tx #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .data_in(data_in),
    .rx_out (rx_out)
  );

  always #5 clock = ~clock;

  // Expected line level i cycles after the edge that accepts the start edge:
  // idle high, then start(0), data LSB first, stop(1), each N cycles long.
  function automatic logic exp_line(input logic [7:0] b, input int i);
    logic [9:0] bits;
    logic [9:0] sh;
    bits = {1'b1, b, 1'b0};
    if (i >= 1 && i <= FRAME) begin
      sh = bits >> ((i - 1) / N);
      return sh[0];
    end
    return 1'b1;
  endfunction

  // Record line, TX state and receiver pulses after each of the next n edges.
  task automatic capture(input int n);
    valid_cnt  = 0;
    valid_data = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cap_line[i]  = rx_out;
      cap_state[i] = dut.state;
      if (dut.rx_valid === 1'b1) begin
        valid_cnt++;
        valid_data = dut.rx_data;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start   = 1'b0;
    data_in = 8'($urandom);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (rx_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_line got=%b exp=1", rx_out);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE);
    end
    checks++;
    if (dut.rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_data got=%02h exp=00", dut.rx_data);
    end
    checks++;
    if (dut.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_err got=%b exp=0", dut.frame_err);
    end
    checks++;
    if (dut.rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rx_valid got=%b exp=0", dut.rx_valid);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input string tag);
    int errs;
    @(negedge clock);
    data_in = b;
    start   = 1'b1;
    fork
      capture(FRAME + 2 * N);
      begin
        repeat (10) @(negedge clock);
        start = 1'b0;
      end
    join
    for (int j = 0; j < FRAME_BITS; j++) begin
      errs = 0;
      for (int c = 1 + j * N; c <= (j + 1) * N; c++)
        if (cap_line[c] !== exp_line(b, c)) errs++;
      checks++;
      if (errs != 0) begin
        failures++;
        $display("FAIL %s_bit%0d byte=%02h mid got=%b exp=%b bad_cycles=%0d", tag, j, b,
                 cap_line[j * N + N / 2 + 1], exp_line(b, j * N + N / 2 + 1), errs);
      end
    end
    errs = (cap_line[0] !== 1'b1) ? 1 : 0;
    for (int c = FRAME + 1; c < FRAME + 2 * N; c++)
      if (cap_line[c] !== 1'b1) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s_idle_line byte=%02h low_cycles=%0d exp=0", tag, b, errs);
    end
    checks++;
    if (valid_cnt != 1) begin
      failures++;
      $display("FAIL %s_valid_count got=%0d exp=1", tag, valid_cnt);
    end
    checks++;
    if (valid_data !== b) begin
      failures++;
      $display("FAIL %s_rx_data got=%02h exp=%02h", tag, valid_data, b);
    end
    checks++;
    if (cap_state[FRAME] !== IDLE || cap_state[FRAME - 1] === IDLE) begin
      failures++;
      $display("FAIL %s_idle_return got=%0d,%0d exp=busy,%0d", tag,
               cap_state[FRAME - 1], cap_state[FRAME], IDLE);
    end
    checks++;
    if (dut.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_frame_err got=%b exp=0", tag, dut.frame_err);
    end
  endtask

  task automatic test_random_bytes();
    for (int n = 0; n < 3; n++) test_frame(8'($urandom), "frame_rand");
  endtask

  task automatic test_start_held();
    logic [7:0] b;
    int errs;
    b = 8'($urandom);
    @(negedge clock);
    data_in = b;
    start   = 1'b1;
    capture(2 * FRAME + 2 * N);
    @(negedge clock);
    start = 1'b0;
    errs = 0;
    for (int c = 0; c < 2 * FRAME + 2 * N; c++)
      if (cap_line[c] !== exp_line(b, c)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL held_line byte=%02h bad_cycles=%0d exp=0", b, errs);
    end
    checks++;
    if (valid_cnt != 1 || valid_data !== b) begin
      failures++;
      $display("FAIL held_rx got=%0d/%02h exp=1/%02h", valid_cnt, valid_data, b);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] b;
    int errs;
    b = 8'($urandom);
    @(negedge clock);
    data_in = b;
    start   = 1'b1;
    fork
      capture(2 * FRAME + 2 * N);
      begin
        repeat (10) @(negedge clock);
        start = 1'b0;
        repeat (5 * N - 10) @(negedge clock);
        data_in = ~b;
        start   = 1'b1;
        repeat (10) @(negedge clock);
        start = 1'b0;
      end
    join
    errs = 0;
    for (int c = 0; c < 2 * FRAME + 2 * N; c++)
      if (cap_line[c] !== exp_line(b, c)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL retrigger_line byte=%02h bad_cycles=%0d exp=0", b, errs);
    end
    checks++;
    if (valid_cnt != 1 || valid_data !== b) begin
      failures++;
      $display("FAIL retrigger_rx got=%0d/%02h exp=1/%02h", valid_cnt, valid_data, b);
    end
  endtask

  task automatic test_data_change();
    int errs;
    @(negedge clock);
    data_in = 8'hBA;
    start   = 1'b1;
    fork
      capture(FRAME + 2 * N);
      begin
        repeat (10) @(negedge clock);
        start = 1'b0;
        repeat (4 * N - 10) @(negedge clock);
        data_in = 8'h00;
      end
    join
    errs = 0;
    for (int c = 0; c < FRAME + 2 * N; c++)
      if (cap_line[c] !== exp_line(8'hBA, c)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL data_change_line bad_cycles=%0d exp=0", errs);
    end
    checks++;
    if (valid_cnt != 1 || valid_data !== 8'hBA) begin
      failures++;
      $display("FAIL data_change_rx got=%0d/%02h exp=1/ba", valid_cnt, valid_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int low_cnt;
    int pulses;
    // Bit 3 forced low so the abort is visible as the line jumping high.
    b = 8'($urandom) & 8'hF7;
    @(negedge clock);
    data_in = b;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4 * N + N / 2) @(negedge clock);
    checks++;
    if (rx_out !== exp_line(b, 4 * N + N / 2 + 1)) begin
      failures++;
      $display("FAIL reset_mid_bit3 got=%b exp=%b", rx_out, exp_line(b, 4 * N + N / 2 + 1));
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (rx_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_line got=%b exp=1", rx_out);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_state got=%0d exp=%0d", dut.state, IDLE);
    end
    @(negedge clock);
    reset   = 1'b1;
    low_cnt = 0;
    pulses  = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clock);
      #1;
      if (rx_out !== 1'b1) low_cnt++;
      if (dut.rx_valid !== 1'b0) pulses++;
    end
    checks++;
    if (low_cnt != 0 || pulses != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet low_cycles=%0d pulses=%0d exp=0/0", low_cnt, pulses);
    end
    checks++;
    if (dut.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame_err got=%b exp=0", dut.frame_err);
    end
    test_frame(8'h55, "after_reset");
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame(8'hBA, "frame_ba");
    test_random_bytes();
    test_start_held();
    test_retrigger();
    test_data_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
